pc_fetch_ctrl: RTL and testbench

PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

---
 rtl/pc_fetch_ctrl.sv | 92 +++++++++
 tb/tb_pc_fetch_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_ctrl.sv
// Program-counter and instruction-fetch controller: fetches one word per
// instruction, hands it to execute, and stops on halt, fetch timeout or misaligned PC.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [7:0]  TIMEOUT  = 8'd15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] npc_in,
  output logic [31:0] ins_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ins,
  output logic        ins_valid,
  input  logic        ins_ready,
  input  logic        halt,
  output logic        halted,
  output logic        fault,
  output logic [1:0]  fault_code,
  output logic [31:0] fault_addr,
  output logic [31:0] retired_cnt
);

  localparam logic [1:0] S_FETCH  = 2'd0;
  localparam logic [1:0] S_EXEC   = 2'd1;
  localparam logic [1:0] S_HALTED = 2'd2;
  localparam logic [1:0] S_FAULT  = 2'd3;

  localparam logic [1:0] FC_TIMEOUT    = 2'b01;
  localparam logic [1:0] FC_MISALIGNED = 2'b10;

  logic [1:0]  state;
  logic [31:0] pc;
  logic [7:0]  timer;

  // HALTED and FAULT have no exits; only rst leaves them.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_FETCH;
      pc          <= RESET_PC;
      timer       <= 8'd0;
      ins         <= 32'd0;
      retired_cnt <= 32'd0;
      fault_code  <= 2'b00;
      fault_addr  <= 32'd0;
    end else begin
      case (state)
        S_FETCH: begin
          if (imem_ack) begin
            ins   <= imem_rdata;
            timer <= 8'd0;
            state <= S_EXEC;
          end else if (timer == TIMEOUT - 8'd1) begin
            state      <= S_FAULT;
            fault_code <= FC_TIMEOUT;
            fault_addr <= pc;
          end else begin
            timer <= timer + 8'd1;
          end
        end
        S_EXEC: begin
          if (ins_ready) begin
            // The instruction retires even when its successor address faults.
            retired_cnt <= retired_cnt + 32'd1;
            if (halt) begin
              state <= S_HALTED;
            end else if (npc_in[1:0] != 2'b00) begin
              state      <= S_FAULT;
              fault_code <= FC_MISALIGNED;
              fault_addr <= npc_in;
            end else begin
              pc    <= npc_in;
              state <= S_FETCH;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign ins_addr  = pc;
  assign imem_addr = pc;
  assign imem_req  = (state == S_FETCH);
  assign ins_valid = (state == S_EXEC);
  assign halted    = (state == S_HALTED);
  assign fault     = (state == S_FAULT);

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Testbench for pc_fetch_ctrl: directed stimulus, a behavioural reference model
// checked every cycle, and hand-computed literal checks at key points.
module tb_pc_fetch_ctrl;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam int          TIMEOUT  = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] npc_in = 32'd0;
  logic [31:0] ins_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic [31:0] ins;
  logic        ins_valid;
  logic        ins_ready = 1'b0;
  logic        halt = 1'b0;
  logic        halted;
  logic        fault;
  logic [1:0]  fault_code;
  logic [31:0] fault_addr;
  logic [31:0] retired_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  pc_fetch_ctrl #(.RESET_PC(RESET_PC), .TIMEOUT(8'd15)) dut (
    .clk(clk), .rst(rst), .npc_in(npc_in), .ins_addr(ins_addr),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .ins(ins), .ins_valid(ins_valid),
    .ins_ready(ins_ready), .halt(halt), .halted(halted), .fault(fault),
    .fault_code(fault_code), .fault_addr(fault_addr), .retired_cnt(retired_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: phase of the instruction life cycle plus architectural values.
  localparam int PH_WAIT_MEM = 0, PH_WAIT_EXE = 1, PH_STOPPED = 2, PH_BROKEN = 3;
  int          m_phase = PH_WAIT_MEM;
  bit          m_known = 1'b0;
  int          m_misses = 0;
  logic [31:0] m_pc = '0, m_ins = '0, m_cnt = '0, m_faddr = '0;
  logic [1:0]  m_code = '0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic model_step();
    if (rst) begin
      m_known = 1'b1; m_phase = PH_WAIT_MEM; m_pc = RESET_PC; m_misses = 0;
      m_ins = '0; m_cnt = '0; m_code = '0; m_faddr = '0;
    end else if (m_known) begin
      if (m_phase == PH_WAIT_MEM) begin
        if (imem_ack) begin
          m_ins = imem_rdata; m_misses = 0; m_phase = PH_WAIT_EXE;
        end else begin
          m_misses++;
          if (m_misses >= TIMEOUT) begin
            m_phase = PH_BROKEN; m_code = 2'd1; m_faddr = m_pc;
          end
        end
      end else if (m_phase == PH_WAIT_EXE && ins_ready) begin
        m_cnt = m_cnt + 32'd1;
        if (halt) m_phase = PH_STOPPED;
        else if (npc_in % 4 != 0) begin
          m_phase = PH_BROKEN; m_code = 2'd2; m_faddr = npc_in;
        end else begin
          m_pc = npc_in; m_phase = PH_WAIT_MEM;
        end
      end
    end
  endtask

  // Every-cycle comparison, sampled 1 time unit after the active edge.
  always @(posedge clk) begin
    model_step();
    #1;
    if (m_known) begin
      check_output("imem_req",    {31'd0, imem_req},  {31'd0, m_phase == PH_WAIT_MEM});
      check_output("ins_valid",   {31'd0, ins_valid}, {31'd0, m_phase == PH_WAIT_EXE});
      check_output("halted",      {31'd0, halted},    {31'd0, m_phase == PH_STOPPED});
      check_output("fault",       {31'd0, fault},     {31'd0, m_phase == PH_BROKEN});
      check_output("imem_addr",   imem_addr,   m_pc);
      check_output("ins_addr",    ins_addr,    m_pc);
      check_output("ins",         ins,         m_ins);
      check_output("retired_cnt", retired_cnt, m_cnt);
      check_output("fault_code",  {30'd0, fault_code}, {30'd0, m_code});
      check_output("fault_addr",  fault_addr,  m_faddr);
    end
  end

  task automatic apply_stimulus(input logic r, input logic ack, input logic [31:0] rdata,
                                input logic rdy, input logic h, input logic [31:0] npc);
    @(negedge clk);
    rst = r; imem_ack = ack; imem_rdata = rdata; ins_ready = rdy; halt = h; npc_in = npc;
  endtask

  task automatic do_reset();
    apply_stimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    apply_stimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
  endtask

  initial begin
    do_reset();
    // First cycle after reset release.
    check_output("lit_rst_req",  {31'd0, imem_req}, 32'd1);
    check_output("lit_rst_addr", imem_addr, 32'h0000_3000);
    check_output("lit_rst_cnt",  retired_cnt, 32'd0);

    // Two-cycle instruction.
    apply_stimulus(1'b0, 1'b1, 32'h2408_0001, 1'b0, 1'b0, 32'd0);
    apply_stimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'h0000_3004);
    check_output("lit_ins",       ins, 32'h2408_0001);
    check_output("lit_ins_valid", {31'd0, ins_valid}, 32'd1);
    apply_stimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    check_output("lit_addr_3004", imem_addr, 32'h0000_3004);
    check_output("lit_cnt_1",     retired_cnt, 32'd1);

    // 14 missed acks then an ack: no fault.
    for (int i = 0; i < 13; i++) apply_stimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    apply_stimulus(1'b0, 1'b1, 32'hAAAA_0001, 1'b0, 1'b0, 32'd0);
    apply_stimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    check_output("lit_late_ack_exec", {31'd0, ins_valid}, 32'd1);
    check_output("lit_late_ack_nofault", {31'd0, fault}, 32'd0);
    apply_stimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'h0000_3008);

    // Stall in execute with toggling npc_in and halt.
    apply_stimulus(1'b0, 1'b1, 32'hBBBB_0002, 1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 5; i++)
      apply_stimulus(1'b0, 1'b1, 32'hDEAD_0000, 1'b0, i[0], 32'h0000_4000 + 32'(i));
    check_output("lit_stall_pc",  ins_addr, 32'h0000_3008);
    check_output("lit_stall_ins", ins, 32'hBBBB_0002);
    apply_stimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'h0000_3010);
    apply_stimulus(1'b0, 1'b1, 32'hCCCC_0003, 1'b0, 1'b0, 32'd0);
    check_output("lit_addr_3010", imem_addr, 32'h0000_3010);

    // Misaligned next PC.
    apply_stimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'h0000_3006);
    apply_stimulus(1'b0, 1'b1, 32'h1111_1111, 1'b1, 1'b0, 32'h0000_3020);
    check_output("lit_mis_code", {30'd0, fault_code}, 32'd2);
    check_output("lit_mis_addr", fault_addr, 32'h0000_3006);
    check_output("lit_mis_pc",   ins_addr, 32'h0000_3010);
    check_output("lit_mis_cnt",  retired_cnt, 32'd4);
    for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 1'b1, 32'h2222_2222, 1'b1, 1'b1, 32'd0);

    // Fetch timeout after 15 missed acks.
    do_reset();
    for (int i = 0; i < 15; i++) apply_stimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    check_output("lit_to_fault", {31'd0, fault}, 32'd1);
    check_output("lit_to_code",  {30'd0, fault_code}, 32'd1);
    check_output("lit_to_addr",  fault_addr, 32'h0000_3000);
    check_output("lit_to_req",   {31'd0, imem_req}, 32'd0);

    // Halt; later acks are ignored.
    do_reset();
    apply_stimulus(1'b0, 1'b1, 32'h0000_000C, 1'b0, 1'b0, 32'd0);
    apply_stimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 32'h0000_3005);
    for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 1'b1, 32'h3333_3333, 1'b1, 1'b0, 32'h0000_3004);
    check_output("lit_halted",    {31'd0, halted}, 32'd1);
    check_output("lit_halt_cnt",  retired_cnt, 32'd1);
    check_output("lit_halt_ins",  ins, 32'h0000_000C);

    // Counter wrap, then reset in the middle of execute.
    do_reset();
    apply_stimulus(1'b0, 1'b1, 32'h4444_4444, 1'b0, 1'b0, 32'd0);
    @(negedge clk);
    imem_ack = 1'b0;
    force dut.retired_cnt = 32'hFFFF_FFFF;
    m_cnt = 32'hFFFF_FFFF;
    #1 release dut.retired_cnt;
    ins_ready = 1'b1; npc_in = 32'h0000_3004;
    apply_stimulus(1'b0, 1'b1, 32'h5555_5555, 1'b0, 1'b0, 32'd0);
    check_output("lit_wrap", retired_cnt, 32'd0);
    apply_stimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    apply_stimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    check_output("lit_mid_rst_pc",    ins_addr, 32'h0000_3000);
    check_output("lit_mid_rst_valid", {31'd0, ins_valid}, 32'd0);
    check_output("lit_mid_rst_req",   {31'd0, imem_req}, 32'd1);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
